// File: rtl/axi_slave_wr_push_pkg.sv
// Shared types and entry widths for the AXI slave write-ingress path.
package axi_slave_package;

    // {AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWUSER} at the default widths
    localparam int unsigned AW_ENTRY_WIDTH = 4 + 64 + 8 + 3 + 2 + 3;
    // {WDATA, WSTRB, last} at 128 bytes per beat
    localparam int unsigned W_ENTRY_WIDTH  = 1024 + 128 + 1;

    typedef enum logic [1:0] {
        wr_Idle,
        AW_Push,
        W_Push,
        waiting_beat
    } request_push_fsm_wr_state;

endpackage

// File: rtl/axi_beat_counter.sv
// Down-counter of remaining W beats in the current burst; saturates at zero.
module axi_beat_counter #(
    parameter int unsigned LEN_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [LEN_WIDTH-1:0] load_val,
    input  logic                 dec,
    output logic                 is_zero
);

    logic [LEN_WIDTH-1:0] cnt_q;

    // Load wins over decrement; decrement never wraps below zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (dec && !is_zero) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign is_zero = (cnt_q == '0);

endmodule

// File: rtl/axi_slave_wr_push.sv
// AXI4 write ingress: one AW entry per burst, then AWLEN+1 W entries, last tagged by count.
module axi_slave_wr_push
    import axi_slave_package::*;
#(
    parameter int unsigned ID_WIDTH     = 4,
    parameter int unsigned ADDR_WIDTH   = 64,
    parameter int unsigned LEN_WIDTH    = 8,
    parameter int unsigned AWUSER_WIDTH = 3,
    parameter int unsigned DATA_BYTES   = 128
) (
    input  logic                      ACLK,
    input  logic                      ARESET,
    input  logic [ID_WIDTH-1:0]       AWID,
    input  logic [ADDR_WIDTH-1:0]     AWADDR,
    input  logic [LEN_WIDTH-1:0]      AWLEN,
    input  logic [2:0]                AWSIZE,
    input  logic [1:0]                AWBURST,
    input  logic [AWUSER_WIDTH-1:0]   AWUSER,
    input  logic                      AWVALID,
    output logic                      AWREADY,
    input  logic [8*DATA_BYTES-1:0]   WDATA,
    input  logic [DATA_BYTES-1:0]     WSTRB,
    input  logic                      WLAST,
    input  logic                      WVALID,
    output logic                      WREADY,
    input  logic                      aw_fifo_full,
    output logic                      aw_push,
    output logic [AW_ENTRY_WIDTH-1:0] aw_entry,
    input  logic                      w_fifo_full,
    output logic                      w_push,
    output logic [W_ENTRY_WIDTH-1:0]  w_entry,
    output logic                      wlast_err
);

    request_push_fsm_wr_state state_q, state_d;

    logic [ID_WIDTH-1:0]     awid_q;
    logic [ADDR_WIDTH-1:0]   awaddr_q;
    logic [LEN_WIDTH-1:0]    awlen_q;
    logic [2:0]              awsize_q;
    logic [1:0]              awburst_q;
    logic [AWUSER_WIDTH-1:0] awuser_q;
    logic                    aw_hs;
    logic                    w_hs;
    logic                    beat_zero;
    logic                    wlast_err_q;

    axi_beat_counter #(
        .LEN_WIDTH (LEN_WIDTH)
    ) u_beat_counter (
        .clk      (ACLK),
        .rst      (ARESET),
        .load     (aw_hs),
        .load_val (AWLEN),
        .dec      (w_hs),
        .is_zero  (beat_zero)
    );

    // State register.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q <= wr_Idle;
        end else begin
            state_q <= state_d;
        end
    end

    // Burst header capture and WLAST cross-check against the beat count.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            awid_q      <= '0;
            awaddr_q    <= '0;
            awlen_q     <= '0;
            awsize_q    <= '0;
            awburst_q   <= '0;
            awuser_q    <= '0;
            wlast_err_q <= 1'b0;
        end else begin
            if (aw_hs) begin
                awid_q    <= AWID;
                awaddr_q  <= AWADDR;
                awlen_q   <= AWLEN;
                awsize_q  <= AWSIZE;
                awburst_q <= AWBURST;
                awuser_q  <= AWUSER;
            end
            wlast_err_q <= w_hs && (WLAST != beat_zero);
        end
    end

    // Handshake outputs, pushes and next state; ready/push gated off while reset is held.
    always_comb begin
        state_d = state_q;
        AWREADY = 1'b0;
        WREADY  = 1'b0;
        aw_push = 1'b0;
        unique case (state_q)
            wr_Idle: begin
                AWREADY = !ARESET && !aw_fifo_full;
                if (AWVALID && AWREADY) state_d = AW_Push;
            end
            AW_Push: begin
                aw_push = !ARESET;
                state_d = w_fifo_full ? waiting_beat : W_Push;
            end
            W_Push: begin
                WREADY = !ARESET && !w_fifo_full;
                if (WVALID && WREADY) begin
                    if (beat_zero) state_d = wr_Idle;
                end else if (w_fifo_full) begin
                    state_d = waiting_beat;
                end
            end
            waiting_beat: begin
                if (!w_fifo_full) state_d = W_Push;
            end
            default: state_d = wr_Idle;
        endcase
    end

    assign aw_hs     = AWVALID && AWREADY;
    assign w_hs      = WVALID && WREADY;
    assign w_push    = w_hs;
    assign aw_entry  = {awid_q, awaddr_q, awlen_q, awsize_q, awburst_q, awuser_q};
    assign w_entry   = {WDATA, WSTRB, beat_zero};
    assign wlast_err = wlast_err_q;

endmodule

// File: tb/tb_axi_slave_wr_push.sv
// Randomized bench with a burst-level reference model for axi_slave_wr_push.
module tb_axi_slave_wr_push;
    import axi_slave_package::*;

    logic                      ACLK = 1'b0;
    logic                      ARESET;
    logic [3:0]                AWID;
    logic [63:0]               AWADDR;
    logic [7:0]                AWLEN;
    logic [2:0]                AWSIZE;
    logic [1:0]                AWBURST;
    logic [2:0]                AWUSER;
    logic                      AWVALID;
    logic                      AWREADY;
    logic [1023:0]             WDATA;
    logic [127:0]              WSTRB;
    logic                      WLAST;
    logic                      WVALID;
    logic                      WREADY;
    logic                      aw_fifo_full;
    logic                      aw_push;
    logic [AW_ENTRY_WIDTH-1:0] aw_entry;
    logic                      w_fifo_full;
    logic                      w_push;
    logic [W_ENTRY_WIDTH-1:0]  w_entry;
    logic                      wlast_err;

    axi_slave_wr_push dut (
        .ACLK         (ACLK),
        .ARESET       (ARESET),
        .AWID         (AWID),
        .AWADDR       (AWADDR),
        .AWLEN        (AWLEN),
        .AWSIZE       (AWSIZE),
        .AWBURST      (AWBURST),
        .AWUSER       (AWUSER),
        .AWVALID      (AWVALID),
        .AWREADY      (AWREADY),
        .WDATA        (WDATA),
        .WSTRB        (WSTRB),
        .WLAST        (WLAST),
        .WVALID       (WVALID),
        .WREADY       (WREADY),
        .aw_fifo_full (aw_fifo_full),
        .aw_push      (aw_push),
        .aw_entry     (aw_entry),
        .w_fifo_full  (w_fifo_full),
        .w_push       (w_push),
        .w_entry      (w_entry),
        .wlast_err    (wlast_err)
    );

    always #5 ACLK = ~ACLK;

    int total = 0;
    int bad   = 0;

    // Reference model: burst accepted, header push owed, paused on full, beats remaining.
    bit                      busy, aw_due, paused, err_prev, hs_w;
    int                      beats_left;
    logic [AW_ENTRY_WIDTH-1:0] aw_store;

    // Observed DUT event counts, used by the literal checks.
    int obs_aw, obs_w, obs_last, obs_err;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic rand_data();
        for (int i = 0; i < 32; i++) WDATA[i*32 +: 32] = $urandom;
        for (int i = 0; i < 4; i++) WSTRB[i*32 +: 32] = $urandom;
    endtask

    // One cycle: inputs were set at the preceding negedge; compare, advance model, next negedge.
    task automatic step();
        bit exp_awr, exp_wr;
        #1;
        if (ARESET) begin
            chk("rst_awready", AWREADY, 0);
            chk("rst_wready", WREADY, 0);
            chk("rst_aw_push", aw_push, 0);
            chk("rst_w_push", w_push, 0);
            chk("rst_wlast_err", wlast_err, 0);
            busy = 0; aw_due = 0; paused = 0; err_prev = 0; hs_w = 0; beats_left = 0;
        end else begin
            exp_awr = !busy && !aw_fifo_full;
            exp_wr  = busy && !aw_due && !paused && !w_fifo_full;
            hs_w    = exp_wr && WVALID;
            chk("awready", AWREADY, exp_awr);
            chk("wready", WREADY, exp_wr);
            chk("aw_push", aw_push, aw_due);
            chk("w_push", w_push, hs_w);
            chk("wlast_err", wlast_err, err_prev);
            if (aw_due) chk("aw_entry", aw_entry, aw_store);
            if (hs_w) begin
                for (int i = 0; i < 4; i++)
                    chk("w_data", w_entry[129 + i*256 +: 256], WDATA[i*256 +: 256]);
                chk("w_strb", w_entry[128:1], WSTRB);
                chk("w_last", w_entry[0], beats_left == 1);
            end
            err_prev = hs_w && (WLAST != (beats_left == 1));
            if (!busy) begin
                if (AWVALID && !aw_fifo_full) begin
                    busy = 1; aw_due = 1; beats_left = int'(AWLEN) + 1;
                    aw_store = {AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWUSER};
                end
            end else if (aw_due) begin
                aw_due = 0; paused = w_fifo_full;
            end else if (paused) begin
                paused = w_fifo_full;
            end else if (hs_w) begin
                beats_left--;
                if (beats_left == 0) busy = 0;
            end else if (w_fifo_full) begin
                paused = 1;
            end
        end
        if (aw_push) obs_aw++;
        if (w_push) begin
            obs_w++;
            if (w_entry[0]) obs_last++;
        end
        if (wlast_err) obs_err++;
        @(posedge ACLK);
        @(negedge ACLK);
    endtask

    task automatic idle_inputs();
        AWVALID = 0; AWID = 0; AWADDR = 0; AWLEN = 0; AWSIZE = 0; AWBURST = 0; AWUSER = 0;
        WVALID = 0; WLAST = 0; WDATA = '0; WSTRB = '0; aw_fifo_full = 0; w_fifo_full = 0;
    endtask

    // Directed burst: optional stall of the W FIFO, a wrong-WLAST beat, or a reset mid-burst.
    task automatic burst(input int id, input longint addr, input int len, input int stall_at,
                         input int stall_len, input int bad_beat, input int rst_at);
        int beat = 0;
        int stalled = 0;
        int guard = 0;
        AWVALID = 1; AWID = 4'(id); AWADDR = addr; AWLEN = 8'(len);
        AWSIZE = 3'd7; AWBURST = 2'd1; AWUSER = 3'($urandom);
        step();
        AWVALID = 0;
        WVALID = 1;
        while (busy && guard < 2000) begin
            guard++;
            if (rst_at >= 0 && beat == rst_at) begin
                ARESET = 1;
                step();
                step();
                ARESET = 0;
                break;
            end
            rand_data();
            WLAST = (beat == len) ^ (beat == bad_beat);
            w_fifo_full = (beat == stall_at) && (stalled < stall_len);
            if (w_fifo_full) stalled++;
            step();
            if (hs_w) beat++;
        end
        chk("burst_done_in_budget", guard < 2000, 1);
        WVALID = 0; WLAST = 0; w_fifo_full = 0;
    endtask

    initial begin
        int a0, w0, l0, e0;
        busy = 0; aw_due = 0; paused = 0; err_prev = 0; hs_w = 0; beats_left = 0; aw_store = '0;
        obs_aw = 0; obs_w = 0; obs_last = 0; obs_err = 0;
        idle_inputs();
        ARESET = 1;
        @(negedge ACLK);
        chk("reset_aw_entry", aw_entry, 0);
        step();
        step();
        ARESET = 0;
        step();

        // AWLEN=0 single beat with correct WLAST
        a0 = obs_aw; w0 = obs_w; l0 = obs_last; e0 = obs_err;
        burst(3, 64'h1000, 0, -1, 0, -1, -1);
        chk("t1_aw_pushes", 32'(obs_aw - a0), 1);
        chk("t1_w_pushes", 32'(obs_w - w0), 1);
        chk("t1_lasts", 32'(obs_last - l0), 1);
        step();
        chk("t1_errs", 32'(obs_err - e0), 0);

        // AWLEN=3 back-to-back, AWREADY the cycle after beat 4
        a0 = obs_aw; w0 = obs_w; l0 = obs_last;
        burst(5, 64'h2000, 3, -1, 0, -1, -1);
        #1 chk("t2_awready_after_last", AWREADY, 1);
        chk("t2_w_pushes", 32'(obs_w - w0), 4);
        chk("t2_lasts", 32'(obs_last - l0), 1);
        step();

        // AWLEN=7 with a 5-cycle W FIFO stall after beat 2
        w0 = obs_w; l0 = obs_last;
        burst(7, 64'h3000, 7, 2, 5, -1, -1);
        chk("t3_w_pushes", 32'(obs_w - w0), 8);
        chk("t3_lasts", 32'(obs_last - l0), 1);

        // AWLEN=2 with WLAST wrongly on the first beat
        w0 = obs_w; e0 = obs_err;
        burst(1, 64'h4000, 2, -1, 0, 0, -1);
        step();
        chk("t4_w_pushes", 32'(obs_w - w0), 3);
        chk("t4_errs", 32'(obs_err - e0), 1);

        // AW FIFO full holds off the handshake
        a0 = obs_aw;
        AWVALID = 1; AWID = 4'd9; AWADDR = 64'h5000; AWLEN = 0; aw_fifo_full = 1;
        repeat (3) step();
        chk("t5_no_aw_push", 32'(obs_aw - a0), 0);
        aw_fifo_full = 0;
        AWVALID = 0;
        burst(9, 64'h5000, 0, -1, 0, -1, -1);
        chk("t5_aw_push_after", 32'(obs_aw - a0), 1);

        // Reset after beat 5 of an AWLEN=15 burst, then a fresh single-beat burst
        a0 = obs_aw; w0 = obs_w;
        burst(2, 64'h6000, 15, -1, 0, -1, 5);
        chk("t6_w_before_rst", 32'(obs_w - w0), 5);
        step();
        chk("t6_idle_after_rst", 32'(obs_w - w0), 5);
        a0 = obs_aw; w0 = obs_w; l0 = obs_last;
        burst(4, 64'h7000, 0, -1, 0, -1, -1);
        chk("t6_new_aw", 32'(obs_aw - a0), 1);
        chk("t6_new_w", 32'(obs_w - w0), 1);
        chk("t6_new_last", 32'(obs_last - l0), 1);

        // Randomized traffic
        for (int c = 0; c < 6000; c++) begin
            ARESET = ($urandom_range(0, 799) == 0);
            AWVALID = $urandom_range(0, 1) == 1;
            AWID = 4'($urandom); AWADDR = {$urandom, $urandom};
            AWLEN = ($urandom_range(0, 24) == 0) ? 8'd255 : 8'($urandom_range(0, 5));
            AWSIZE = 3'($urandom); AWBURST = 2'($urandom); AWUSER = 3'($urandom);
            WVALID = $urandom_range(0, 3) != 0;
            WLAST = (beats_left == 1) ^ ($urandom_range(0, 15) == 0);
            aw_fifo_full = $urandom_range(0, 4) == 0;
            w_fifo_full = $urandom_range(0, 4) == 0;
            rand_data();
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
